// File: rtl/rgst_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// rgst_serial_tx_pkg
// Shared definitions for the register-unload serial transmitter:
//   - tx_state_t       : frame FSM state encoding (IDLE/START/DATA/STOP)
//   - DEFAULT_N        : default link word width
//   - DEFAULT_CLKS_PER_BIT : default bit period in clk cycles
//   - cnt_width()      : counter width helper, never narrower than 1 bit
// No ports (package).
// ---------------------------------------------------------------------------
package rgst_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_N            = 16;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Width of a counter spanning 0..span-1; a span of 1 still needs one bit.
    function automatic int cnt_width(input int span);
        if (span > 1) begin
            return $clog2(span);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rgst_serial_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// rgst_serial_tx_bit_timer
// Modulo-CLKS_PER_BIT counter that marks the last clk cycle of each serial
// bit period.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   clear in  hold the count at 0 (asserted while the transmitter is idle)
//   tick  out high on the last cycle of a bit period
// ---------------------------------------------------------------------------
module rgst_serial_tx_bit_timer
    import rgst_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Suppressed while cleared so the first bit after acceptance gets a full period.
    assign tick = !clear && (cnt == LAST);

    // Cycle counter within the current bit period; wraps after the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {CW{1'b0}};
        end else if (clear || tick) begin
            cnt <= {CW{1'b0}};
        end else begin
            cnt <= cnt + CW'(1'b1);
        end
    end

endmodule

// File: rtl/rgst_serial_tx.sv
// ---------------------------------------------------------------------------
// rgst_serial_tx
// Transmit side of the register-unload link. Takes one N-bit word through a
// valid/ready handshake and sends it as: start bit (0), N data bits LSB
// first, stop bit (1). Each bit is held for CLKS_PER_BIT clk cycles.
// Ports:
//   clk       in   system clock, posedge
//   rst       in   asynchronous active-high reset (aborts any frame)
//   din       in   [N] word to send, sampled only on the accepting edge
//   din_valid in   producer offers a word
//   din_ready out  high while idle
//   tx        out  serial line, registered, idles high
//   busy      out  frame in progress
//   done      out  one-cycle pulse in the first idle cycle after the stop bit
// ---------------------------------------------------------------------------
module rgst_serial_tx
    import rgst_serial_tx_pkg::*;
#(
    parameter int N            = DEFAULT_N,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int            BW       = cnt_width(N);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    tx_state_t      state;
    logic [BW-1:0]  bit_idx;
    logic [N-1:0]   shreg;
    logic [N-1:0]   shreg_shift;
    logic [N-1:0]   shreg_d;
    logic           shreg_en;
    logic           tick;
    logic           accept;
    logic           last_bit;

    assign din_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = (state == IDLE) && din_valid;
    assign last_bit    = (bit_idx == LAST_BIT);
    // Next word view once the current data bit has been sent; bit 0 is the next tx value.
    assign shreg_shift = shreg >> 1;

    rgst_serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // Shift register next value: load on acceptance, shift after each non-final data bit.
    always_comb begin
        shreg_en = 1'b0;
        shreg_d  = shreg;
        if (accept) begin
            shreg_en = 1'b1;
            shreg_d  = din;
        end else if ((state == DATA) && tick && !last_bit) begin
            shreg_en = 1'b1;
            shreg_d  = shreg_shift;
        end else begin
            shreg_en = 1'b0;
            shreg_d  = shreg;
        end
    end

    // Enable-gated shift/load register holding the word being sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= {N{1'b0}};
        end else if (shreg_en) begin
            shreg <= shreg_d;
        end
    end

    // Frame FSM; tx and done are registered so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            done    <= 1'b0;
            bit_idx <= {BW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        state   <= START;
                        tx      <= 1'b0;
                        bit_idx <= {BW{1'b0}};
                    end else begin
                        tx <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= {BW{1'b0}};
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (last_bit) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BW'(1'b1);
                            tx      <= shreg_shift[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgst_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_rgst_serial_tx
// Self-checking bench: a 16-bit / 4-clk transmitter driven from a vector
// table, an abort sequence and random words, plus a 1-bit / 1-clk instance
// for the minimum-parameter corner.
// ---------------------------------------------------------------------------
module tb_rgst_serial_tx;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b0;

    logic [15:0] din_a   = 16'h0000;
    logic        valid_a = 1'b0;
    logic        ready_a, tx_a, busy_a, done_a;

    logic [0:0]  din_b   = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_b, tx_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] w;
        logic [17:0] fr;      // expected line bits per bit period: start, data LSB first, stop
        bit          hold;    // keep din_valid high and offer the next entry back-to-back
        bit          disturb; // wiggle din/din_valid while data bits are on the line
    } vec_t;

    typedef struct {
        logic [0:0] w;
        logic [2:0] seq;      // seq[k] = tx k cycles after acceptance
    } vec_b_t;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    rgst_serial_tx #(.N(16), .CLKS_PER_BIT(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .din       (din_a),
        .din_valid (valid_a),
        .din_ready (ready_a),
        .tx        (tx_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    rgst_serial_tx #(.N(1), .CLKS_PER_BIT(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .din       (din_b),
        .din_valid (valid_b),
        .din_ready (ready_b),
        .tx        (tx_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_a(input logic [15:0] w);
        din_a   = w;
        valid_a = 1'b1;
    endtask

    // Called with acceptance on the coming posedge; observes the whole frame.
    task automatic frame_body(input logic [15:0] w, input logic [17:0] fr, input bit hold,
                              input logic [15:0] nxt, input bit disturb, input string name);
        int          bad_tx     = 0;
        int          bad_busy   = 0;
        int          bad_ready  = 0;
        int          early_done = 0;
        logic [15:0] dec        = 16'h0000;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            if (tx_a !== fr[k / 4]) bad_tx++;
            if (busy_a !== 1'b1) bad_busy++;
            if (ready_a !== 1'b0) bad_ready++;
            if (done_a !== 1'b0) early_done++;
            // UART-style receiver: sample mid-bit
            if ((k % 4) == 2 && (k / 4) >= 1 && (k / 4) <= 16) dec[k / 4 - 1] = tx_a;
            if (disturb && k >= 8 && k < 64) begin
                din_a   = 16'h1234;
                valid_a = k[0];
            end
            if (!hold && (k == 0 || k == 71)) valid_a = 1'b0;
        end
        check({name, "_tx_wave_errs"}, bad_tx, 0);
        check({name, "_decoded"}, dec, w);
        check({name, "_busy_errs"}, bad_busy, 0);
        check({name, "_ready_errs"}, bad_ready, 0);
        check({name, "_early_done"}, early_done, 0);
        @(negedge clk);
        check({name, "_done_pulse"}, done_a, 1'b1);
        check({name, "_tx_idle"}, tx_a, 1'b1);
        check({name, "_ready_done"}, ready_a, 1'b1);
        check({name, "_busy_done"}, busy_a, 1'b0);
        if (hold) begin
            din_a = nxt;
        end else begin
            valid_a = 1'b0;
            @(negedge clk);
            check({name, "_done_clear"}, done_a, 1'b0);
        end
    endtask

    initial begin
        vec_t        tbl [5];
        vec_b_t      tbl_b [2];
        bit          held;
        bit          h;
        int          bad;
        logic [15:0] cur, nxt;

        tbl[0] = '{w: 16'hA5C3, fr: 18'h34B86, hold: 1'b0, disturb: 1'b0};
        tbl[1] = '{w: 16'h0001, fr: 18'h20002, hold: 1'b1, disturb: 1'b0};
        tbl[2] = '{w: 16'hFFFF, fr: 18'h3FFFE, hold: 1'b0, disturb: 1'b0};
        tbl[3] = '{w: 16'hA5C3, fr: 18'h34B86, hold: 1'b0, disturb: 1'b1};
        tbl[4] = '{w: 16'h0000, fr: 18'h20000, hold: 1'b0, disturb: 1'b0};
        tbl_b[0] = '{w: 1'b1, seq: 3'b110};
        tbl_b[1] = '{w: 1'b0, seq: 3'b100};

        // Reset with the clock stopped: outputs must settle without any edge
        #3 rst = 1'b1;
        #1;
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_done", done_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Vector table, including back-to-back and ignore-while-busy entries
        held = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!held) begin
                @(negedge clk);
                start_a(tbl[i].w);
            end
            frame_body(tbl[i].w, tbl[i].fr, tbl[i].hold,
                       (i + 1 < 5) ? tbl[i + 1].w : 16'h0000, tbl[i].disturb, "tbl");
            held = tbl[i].hold;
        end

        // Abort during data bit 7 (a 0 bit of 16'h1234)
        @(negedge clk);
        start_a(16'h1234);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k == 0) valid_a = 1'b0;
        end
        check("abort_pre_tx", tx_a, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", tx_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("abort_quiet_errs", bad, 0);
        @(negedge clk);
        start_a(16'h00FF);
        frame_body(16'h00FF, 18'h201FE, 1'b0, 16'h0000, 1'b0, "post_abort");

        // Random words, randomly back-to-back, against the frame-format model
        held = 1'b0;
        cur  = 16'($urandom);
        for (int r = 0; r < 6; r++) begin
            nxt = 16'($urandom);
            h   = (r < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!held) begin
                @(negedge clk);
                start_a(cur);
            end
            frame_body(cur, {1'b1, cur, 1'b0}, h, nxt, 1'b0, "rand");
            held = h;
            cur  = nxt;
        end

        // Minimum parameters: N=1, CLKS_PER_BIT=1
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            din_b   = tbl_b[i].w;
            valid_b = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (k == 0) valid_b = 1'b0;
                check("b_tx", tx_b, tbl_b[i].seq[k]);
                check("b_no_early_done", done_b, 1'b0);
            end
            @(negedge clk);
            check("b_done_pulse", done_b, 1'b1);
            check("b_tx_idle", tx_b, 1'b1);
            check("b_ready", ready_b, 1'b1);
            @(negedge clk);
            check("b_done_clear", done_b, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
